// File: rtl/imem_arbiter.sv
// imem_arbiter: owns the single port of the instruction memory and shares it
// between a streaming boot loader (LOAD) and the CPU fetch stage (RUN).
// The CPU is held stalled and fed NOP_WORD until a complete image has been
// written; the word count and a mod-2^32 checksum of that image are reported.
module imem_arbiter #(
  parameter int                   ADDR_W   = 11,
  parameter int                   DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                ld_last,
  input  logic [ADDR_W+1:0]   cpu_pc,
  output logic [DATA_W-1:0]   cpu_instr,
  output logic                cpu_stall,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                load_done,
  output logic [ADDR_W:0]     load_count,
  output logic [DATA_W-1:0]   load_sum,
  output logic                load_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q,   ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   sum_q,   sum_d;
  logic                ovf_q,   ovf_d;
  logic                done_q,  done_d;

  // State and load-statistics registers; reset returns to IDLE with stats cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {ADDR_W{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
      sum_q   <= {DATA_W{1'b0}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start/restart a load, accept loader words, finish on last or depth limit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = {ADDR_W{1'b0}};
          count_d = {(ADDR_W+1){1'b0}};
          sum_d   = {DATA_W{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        // ld_ready is always high in LOAD, so ld_valid alone means accepted.
        if (ld_valid) begin
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          sum_d   = sum_q + ld_data;
          if (ld_last || (ptr_q == PTR_MAX)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            ovf_d   = ~ld_last;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Port mux: loader drives memory in LOAD, CPU fetch drives it in RUN.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = ld_data;
    cpu_stall = 1'b1;
    cpu_instr = NOP_WORD;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        mem_we   = ld_valid;
        mem_addr = ptr_q;
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        mem_addr  = cpu_pc[ADDR_W+1:2];
        cpu_instr = mem_rdata;
      end
      default: begin
        mem_addr = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign load_done  = done_q;
  assign load_count = count_q;
  assign load_sum   = sum_q;
  assign load_ovf   = ovf_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter. The memory is modelled here; the
// expected image, word count and checksum come from a simple array/sum model.
module tb_imem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [31:0]       ld_data = 32'd0;
  logic              ld_last = 1'b0;
  logic [12:0]       cpu_pc = 13'd0;
  logic [31:0]       cpu_instr;
  logic              cpu_stall;
  logic [10:0]       mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              load_done;
  logic [11:0]       load_count;
  logic [31:0]       load_sum;
  logic              load_ovf;

  int n_vec = 0;
  int n_err = 0;

  // environment memory (async read, sync write) and write monitor
  logic [31:0] tb_mem [DEPTH];
  int          wr_cnt = 0;
  int          last_wr_addr = -1;
  // reference model of what should be in memory
  logic [31:0] exp_img [DEPTH];

  assign mem_rdata = tb_mem[mem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_cnt           <= wr_cnt + 1;
      last_wr_addr     <= int'(mem_addr);
    end
  end

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_done(load_done), .load_count(load_count),
    .load_sum(load_sum), .load_ovf(load_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld_valid = 1'b1;
    #3;
    n_vec++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b1 ||
        cpu_instr !== 32'h0 || load_done !== 1'b0 || load_count !== 12'd0 ||
        load_sum !== 32'd0 || load_ovf !== 1'b0 || mem_addr !== 11'd0) begin
      n_err++;
      $display("FAIL reset: rdy=%b we=%b stall=%b instr=%h done=%b cnt=%0d sum=%h ovf=%b addr=%0d, want 0 0 1 0 0 0 0 0 0",
               ld_ready, mem_we, cpu_stall, cpu_instr, load_done, load_count, load_sum, load_ovf, mem_addr);
    end
    ld_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    n_vec++;
    if (ld_ready !== 1'b0 || cpu_stall !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hold: rdy=%b stall=%b, want 0 1", ld_ready, cpu_stall);
    end
  endtask

  task automatic test_basic_load();
    logic [31:0] words [4];
    logic [31:0] exp_sum;
    int w0;
    words[0] = 32'h2001_0005; words[1] = 32'h2002_0003;
    words[2] = 32'h0022_1820; words[3] = 32'h0800_0000;
    exp_sum = 32'd0;
    pulse_start();
    n_vec++;
    if (ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready: rdy=%b stall=%b, want 1 1", ld_ready, cpu_stall);
    end
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      exp_img[i] = words[i];
      exp_sum = exp_sum + words[i];
      #1;
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 11'(i) || mem_wdata !== words[i] || load_done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_write%0d: we=%b addr=%0d wdata=%h done=%b, want 1 %0d %h 0",
                 i, mem_we, mem_addr, mem_wdata, load_done, i, words[i]);
      end
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    n_vec++;
    if (load_done !== 1'b1 || load_count !== 12'd4 || load_sum !== exp_sum ||
        cpu_stall !== 1'b0 || wr_cnt - w0 !== 4 || load_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b cnt=%0d sum=%h stall=%b writes=%0d ovf=%b, want 1 4 %h 0 4 0",
               load_done, load_count, load_sum, cpu_stall, wr_cnt - w0, load_ovf, exp_sum);
    end
    step();
    n_vec++;
    if (load_done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: done=%b, want 0", load_done);
    end
  endtask

  task automatic test_run_fetch();
    cpu_pc = 13'h000C;
    #1;
    n_vec++;
    if (mem_addr !== 11'd3 || cpu_instr !== exp_img[3] || cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c: addr=%0d instr=%h stall=%b, want 3 %h 0", mem_addr, cpu_instr, cpu_stall, exp_img[3]);
    end
    cpu_pc = 13'h000E;
    #1;
    n_vec++;
    if (mem_addr !== 11'd3 || cpu_instr !== exp_img[3]) begin
      n_err++;
      $display("FAIL fetch_e: addr=%0d instr=%h, want 3 %h", mem_addr, cpu_instr, exp_img[3]);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_pc = 13'(i * 4) | 13'($urandom_range(0, 3));
      #1;
      n_vec++;
      if (cpu_instr !== exp_img[i] || mem_we !== 1'b0 || ld_ready !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_%0d: instr=%h we=%b rdy=%b, want %h 0 0", i, cpu_instr, mem_we, ld_ready, exp_img[i]);
      end
    end
  endtask

  // reload from RUN, then valid pattern 1,0,0,1,1(last) with distractions
  task automatic test_gaps();
    logic pat [5];
    logic [31:0] d;
    logic [31:0] exp_sum;
    int exp_ptr, w0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    cpu_pc = 13'h0004;
    ld_start = 1'b1;
    #1;
    n_vec++;
    if (cpu_stall !== 1'b0 || cpu_instr !== exp_img[1]) begin
      n_err++;
      $display("FAIL reload_same_cycle: stall=%b instr=%h, want 0 %h", cpu_stall, cpu_instr, exp_img[1]);
    end
    step();
    ld_start = 1'b0;
    n_vec++;
    if (cpu_stall !== 1'b1 || load_count !== 12'd0 || load_sum !== 32'd0 || ld_ready !== 1'b1 || cpu_instr !== 32'h0) begin
      n_err++;
      $display("FAIL reload_clear: stall=%b cnt=%0d sum=%h rdy=%b instr=%h, want 1 0 0 1 0",
               cpu_stall, load_count, load_sum, ld_ready, cpu_instr);
    end
    exp_ptr = 0; exp_sum = 32'd0; w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      ld_valid = pat[i]; ld_data = d;
      ld_last  = (i == 4) || (i == 1);   // last on an idle cycle must be ignored
      ld_start = (i == 2);               // ignored during LOAD
      #1;
      n_vec++;
      if (mem_we !== pat[i] || mem_addr !== 11'(exp_ptr)) begin
        n_err++;
        $display("FAIL gap%0d: we=%b addr=%0d, want %b %0d", i, mem_we, mem_addr, pat[i], exp_ptr);
      end
      if (pat[i]) begin
        exp_img[exp_ptr] = d;
        exp_sum = exp_sum + d;
        exp_ptr++;
      end
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    n_vec++;
    if (wr_cnt - w0 !== 3 || last_wr_addr !== 2 || load_count !== 12'd3 ||
        load_sum !== exp_sum || load_done !== 1'b1 || cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL gap_end: writes=%0d lastaddr=%0d cnt=%0d sum=%h done=%b stall=%b, want 3 2 3 %h 1 0",
               wr_cnt - w0, last_wr_addr, load_count, load_sum, load_done, cpu_stall, exp_sum);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (tb_mem[i] !== exp_img[i]) begin
        n_err++;
        $display("FAIL gap_mem%0d: got %h, want %h", i, tb_mem[i], exp_img[i]);
      end
    end
  endtask

  // random-length image with random gaps, checked by fetching every word back
  task automatic test_random_load();
    int n, sent;
    logic [31:0] d;
    logic [31:0] exp_sum;
    int errs0;
    n = $urandom_range(5, 40);
    sent = 0; exp_sum = 32'd0;
    pulse_start();
    while (sent < n) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      d = $urandom;
      ld_data = d;
      ld_last = ld_valid && (sent == n - 1);
      if (ld_valid) begin
        exp_img[sent] = d;
        exp_sum = exp_sum + d;
        sent++;
      end
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_vec++;
    if (load_count !== 12'(n) || load_sum !== exp_sum || load_done !== 1'b1 || load_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rand_stats: cnt=%0d sum=%h done=%b ovf=%b, want %0d %h 1 0",
               load_count, load_sum, load_done, load_ovf, n, exp_sum);
    end
    errs0 = 0;
    for (int i = 0; i < n; i++) begin
      cpu_pc = 13'(i * 4);
      #1;
      if (cpu_instr !== exp_img[i]) errs0++;
    end
    n_vec++;
    if (errs0 != 0) begin
      n_err++;
      $display("FAIL rand_fetch: %0d wrong words of %0d, want 0", errs0, n);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] exp_sum;
    int w0;
    exp_sum = 32'd0;
    pulse_start();
    w0 = wr_cnt;
    for (int i = 0; i <= DEPTH; i++) begin
      d = $urandom;
      ld_valid = 1'b1; ld_data = d; ld_last = 1'b0;
      #1;
      if (i < DEPTH) begin
        exp_img[i] = d;
        exp_sum = exp_sum + d;
      end else begin
        n_vec++;
        if (ld_ready !== 1'b0 || mem_we !== 1'b0 || load_done !== 1'b1 || load_ovf !== 1'b1 ||
            load_count !== 12'd2048 || load_sum !== exp_sum || cpu_stall !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_end: rdy=%b we=%b done=%b ovf=%b cnt=%0d sum=%h stall=%b, want 0 0 1 1 2048 %h 0",
                   ld_ready, mem_we, load_done, load_ovf, load_count, load_sum, cpu_stall, exp_sum);
        end
      end
      step();
    end
    ld_valid = 1'b0;
    n_vec++;
    if (wr_cnt - w0 !== DEPTH || last_wr_addr !== DEPTH - 1 || tb_mem[DEPTH-1] !== exp_img[DEPTH-1] ||
        load_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_writes: writes=%0d lastaddr=%0d mem2047=%h ovf=%b, want 2048 2047 %h 1",
               wr_cnt - w0, last_wr_addr, tb_mem[DEPTH-1], load_ovf, exp_img[DEPTH-1]);
    end
    // reload clears sticky overflow and restarts at address 0
    pulse_start();
    n_vec++;
    if (load_ovf !== 1'b0 || load_count !== 12'd0 || cpu_stall !== 1'b1 || mem_addr !== 11'd0) begin
      n_err++;
      $display("FAIL ovf_reload: ovf=%b cnt=%0d stall=%b addr=%0d, want 0 0 1 0",
               load_ovf, load_count, cpu_stall, mem_addr);
    end
    d = $urandom;
    ld_valid = 1'b1; ld_data = d; ld_last = 1'b1;
    exp_img[0] = d;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    n_vec++;
    if (last_wr_addr !== 0 || load_count !== 12'd1 || load_sum !== d || load_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_restart: lastaddr=%0d cnt=%0d sum=%h ovf=%b, want 0 1 %h 0",
               last_wr_addr, load_count, load_sum, load_ovf, d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [31:0] exp_sum;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      ld_valid = 1'b1; ld_data = d; ld_last = 1'b0;
      exp_img[i] = d;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b1 ||
        load_count !== 12'd0 || load_sum !== 32'd0) begin
      n_err++;
      $display("FAIL async_rst: rdy=%b we=%b stall=%b cnt=%0d sum=%h, want 0 0 1 0 0",
               ld_ready, mem_we, cpu_stall, load_count, load_sum);
    end
    ld_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_vec++;
    if (cpu_stall !== 1'b1 || tb_mem[0] !== exp_img[0] || tb_mem[1] !== exp_img[1]) begin
      n_err++;
      $display("FAIL async_keep: stall=%b mem0=%h mem1=%h, want 1 %h %h",
               cpu_stall, tb_mem[0], tb_mem[1], exp_img[0], exp_img[1]);
    end
    // complete load releases the CPU
    pulse_start();
    exp_sum = 32'd0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      ld_valid = 1'b1; ld_data = d; ld_last = (i == 2);
      exp_img[i] = d;
      exp_sum = exp_sum + d;
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    cpu_pc = 13'h0008;
    #1;
    n_vec++;
    if (cpu_stall !== 1'b0 || load_count !== 12'd3 || load_sum !== exp_sum || cpu_instr !== exp_img[2]) begin
      n_err++;
      $display("FAIL async_reload: stall=%b cnt=%0d sum=%h instr=%h, want 0 3 %h %h",
               cpu_stall, load_count, load_sum, cpu_instr, exp_sum, exp_img[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 32'd0;
      exp_img[i] = 32'd0;
    end
    test_reset();
    test_basic_load();
    test_run_fetch();
    test_gaps();
    test_random_load();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
